spr_writeback_arbiter: RTL and testbench

- Shares the single write port of the special-purpose register file (XER, LR, CTR) among NUM_UNITS execution units that produce SPR results.
- Round-robin arbitrates unit results into a one-entry output stage, broadcasts each result on the SPR result bus to the reservation stations, and writes the SPR file.
- Drops the register-file write when a newer reservation station already owns the target register (stale result), but still broadcasts it.

---
 rtl/spr_writeback_arbiter_pkg.sv | 25 ++
 rtl/spr_writeback_arbiter_rr.sv | 62 ++++++
 rtl/spr_writeback_arbiter.sv | 104 ++++++++++
 tb/tb_spr_writeback_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spr_writeback_arbiter_pkg.sv
// rtl/spr_writeback_arbiter_pkg.sv - shared SPR types for the SPR writeback path
// Package ppc_types:
//   SPR_XER/SPR_LR/SPR_CTR   SPR numbers held in the renamed SPR file
//   SPR_RS_ID_WIDTH          reservation station ID width of the SPR file
//   spr_result_t             {addr, value, rs_id} of one SPR result
//   is_renamed_spr(addr)     1 when addr names a register of the SPR file
package ppc_types;

  localparam int SPR_RS_ID_WIDTH = 5;

  localparam logic [0:9] SPR_XER = 10'd1;
  localparam logic [0:9] SPR_LR  = 10'd8;
  localparam logic [0:9] SPR_CTR = 10'd9;

  typedef struct packed {
    logic [0:9]                 addr;
    logic [0:31]                value;
    logic [0:SPR_RS_ID_WIDTH-1] rs_id;
  } spr_result_t;

  function automatic logic is_renamed_spr(input logic [0:9] addr);
    return (addr == SPR_XER) || (addr == SPR_LR) || (addr == SPR_CTR);
  endfunction

endpackage

// File: rtl/spr_writeback_arbiter_rr.sv
// rtl/spr_writeback_arbiter_rr.sv - round-robin arbiter with its own pointer
// Ports:
//   clk, rst    clock, synchronous active-high reset (pointer -> 0)
//   req[N]      requesters
//   advance     consumer takes the grant this cycle; pointer moves past it
//   grant[N]    one-hot grant: first req at or above the pointer, wrapping
//   any_grant   at least one req is high
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any_grant
);
  import ppc_types::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] next_ptr;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Scan downward so the last hit, i.e. the nearest requester at or after
  // rr_ptr, is the one that survives.
  always_comb begin
    logic [PW-1:0] idx;
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = wrap_add(rr_ptr, k);
      if (req[idx]) begin
        grant          = '0;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
        any_grant      = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && any_grant) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/spr_writeback_arbiter.sv
// rtl/spr_writeback_arbiter.sv - shares the SPR-file write port among units
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   unit_valid/ready[NUM_UNITS]  per-unit result handshake (ready is combinational)
//   unit_addr/value/rs_id        per-unit result fields
//   cdb_valid/ready/rs_id/value  result bus broadcast of the output stage
//   tag_read_addr                SPR-file tag read address (= stage addr)
//   tag_read_value_valid/rs_id   current owner state of that SPR
//   write_addr/enable/value      SPR-file write port
//   err_bad_addr                 pulse: retired result named a non-renamed SPR
//   stale_drop                   pulse: retired result skipped the write (stale)
module spr_writeback_arbiter
  import ppc_types::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_UNITS-1:0]                    unit_valid,
  output logic [NUM_UNITS-1:0]                    unit_ready,
  input  logic [NUM_UNITS-1:0][0:9]               unit_addr,
  input  logic [NUM_UNITS-1:0][0:31]              unit_value,
  input  logic [NUM_UNITS-1:0][0:RS_ID_WIDTH-1]   unit_rs_id,
  output logic                                    cdb_valid,
  input  logic                                    cdb_ready,
  output logic [0:RS_ID_WIDTH-1]                  cdb_rs_id,
  output logic [0:31]                             cdb_value,
  output logic [0:9]                              tag_read_addr,
  input  logic                                    tag_read_value_valid,
  input  logic [0:RS_ID_WIDTH-1]                  tag_read_rs_id,
  output logic [0:9]                              write_addr,
  output logic                                    write_enable,
  output logic [0:31]                             write_value,
  output logic                                    err_bad_addr,
  output logic                                    stale_drop
);

  spr_result_t          stage;
  spr_result_t          sel;
  logic                 full;
  logic                 retire;
  logic                 accept;
  logic                 accept_fire;
  logic                 addr_ok;
  logic                 owner_match;
  logic [NUM_UNITS-1:0] grant;
  logic                 any_grant;

  rr_arbiter #(.N(NUM_UNITS)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (unit_valid),
    .advance   (accept),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Nothing retires or is accepted while rst is high, so the reset cycle
  // neither writes the SPR file nor drops a unit's result on the floor.
  assign retire      = !rst && full && cdb_ready;
  assign accept      = !rst && (!full || retire);
  assign accept_fire = accept && any_grant;
  assign unit_ready  = accept ? grant : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        sel.addr  = unit_addr[i];
        sel.value = unit_value[i];
        sel.rs_id = unit_rs_id[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      stage <= '0;
    end else if (accept_fire) begin
      full  <= 1'b1;
      stage <= sel;
    end else if (retire) begin
      full  <= 1'b0;
    end
  end

  // The result only owns the register if the file still waits on this RS;
  // otherwise a newer producer has renamed it and the write is stale.
  assign addr_ok     = is_renamed_spr(stage.addr);
  assign owner_match = !tag_read_value_valid && (tag_read_rs_id == stage.rs_id);

  assign cdb_valid     = full;
  assign cdb_rs_id     = stage.rs_id;
  assign cdb_value     = stage.value;
  assign tag_read_addr = stage.addr;
  assign write_addr    = stage.addr;
  assign write_value   = stage.value;
  assign write_enable  = retire && addr_ok && owner_match;
  assign stale_drop    = retire && addr_ok && !owner_match;
  assign err_bad_addr  = retire && !addr_ok;

endmodule

// File: tb/tb_spr_writeback_arbiter.sv
// tb/tb_spr_writeback_arbiter.sv - scoreboard bench for spr_writeback_arbiter
module tb_spr_writeback_arbiter;

  localparam int N  = 4;
  localparam int RW = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             unit_valid;
  logic [N-1:0]             unit_ready;
  logic [N-1:0][0:9]        unit_addr;
  logic [N-1:0][0:31]       unit_value;
  logic [N-1:0][0:RW-1]     unit_rs_id;
  logic                     cdb_valid;
  logic                     cdb_ready;
  logic [0:RW-1]            cdb_rs_id;
  logic [0:31]              cdb_value;
  logic [0:9]               tag_read_addr;
  logic                     tag_read_value_valid;
  logic [0:RW-1]            tag_read_rs_id;
  logic [0:9]               write_addr;
  logic                     write_enable;
  logic [0:31]              write_value;
  logic                     err_bad_addr;
  logic                     stale_drop;

  always #5 clk = ~clk;

  spr_writeback_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .unit_valid           (unit_valid),
    .unit_ready           (unit_ready),
    .unit_addr            (unit_addr),
    .unit_value           (unit_value),
    .unit_rs_id           (unit_rs_id),
    .cdb_valid            (cdb_valid),
    .cdb_ready            (cdb_ready),
    .cdb_rs_id            (cdb_rs_id),
    .cdb_value            (cdb_value),
    .tag_read_addr        (tag_read_addr),
    .tag_read_value_valid (tag_read_value_valid),
    .tag_read_rs_id       (tag_read_rs_id),
    .write_addr           (write_addr),
    .write_enable         (write_enable),
    .write_value          (write_value),
    .err_bad_addr         (err_bad_addr),
    .stale_drop           (stale_drop)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] value;
    logic [4:0]  rs;
  } exp_t;

  exp_t       exp_q[$];
  int         passed = 0;
  int         total  = 0;
  int         m_ptr  = 0;
  bit         m_full = 0;
  int         m_last = -1;

  // SPR file owner table: slot 0=XER, 1=LR, 2=CTR
  bit         own_v[3];
  logic [4:0] own_rs[3];

  function automatic int spr_slot(input logic [9:0] a);
    if (a == 10'd1) return 0;
    if (a == 10'd8) return 1;
    if (a == 10'd9) return 2;
    return -1;
  endfunction

  always_comb begin
    int s;
    tag_read_value_valid = 1'b0;
    tag_read_rs_id       = '0;
    s = spr_slot(tag_read_addr);
    if (s >= 0) begin
      tag_read_value_valid = own_v[s];
      tag_read_rs_id       = own_rs[s];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
  endtask

  // Reference model: one clock of the arbiter, evaluated at the negedge.
  task automatic cycle();
    bit           acc;
    int           g;
    logic [N-1:0] eg;
    @(negedge clk);
    check("cdb_valid", 64'(cdb_valid), 64'(m_full));
    acc = !rst && (!m_full || cdb_ready);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && unit_valid[j]) g = j;
    end
    eg = '0;
    if (acc && g >= 0) eg[g] = 1'b1;
    check("unit_ready", 64'(unit_ready), 64'(eg));
    m_last = -1;
    if (rst) begin
      exp_q.delete();
      m_full = 0;
      m_ptr  = 0;
    end else begin
      if (acc && g >= 0) begin
        exp_t e;
        e.addr  = unit_addr[g];
        e.value = unit_value[g];
        e.rs    = unit_rs_id[g];
        exp_q.push_back(e);
        m_ptr  = (g + 1) % N;
        m_last = g;
      end
      m_full = (m_full && !cdb_ready) || (acc && g >= 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every bus retirement is checked against the oldest accepted result.
  always @(negedge clk) begin
    if (!rst && cdb_valid && cdb_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL retire_unexpected actual=retire expected=no_retire");
      end else begin
        exp_t e;
        int   s;
        bit   good;
        bit   we;
        e    = exp_q.pop_front();
        s    = spr_slot(e.addr);
        good = (s >= 0);
        we   = good && !own_v[s] && (own_rs[s] == e.rs);
        check("cdb_rs_id", 64'(cdb_rs_id), 64'(e.rs));
        check("cdb_value", 64'(cdb_value), 64'(e.value));
        check("write_addr_value", {22'd0, write_addr, write_value}, {22'd0, e.addr, e.value});
        check("strobes", 64'({write_enable, stale_drop, err_bad_addr}),
              64'({we, good && !we, !good}));
      end
    end else begin
      check("idle_strobes", 64'({write_enable, stale_drop, err_bad_addr}), 64'(0));
    end
  end

  task automatic set_unit(input int i, input logic [9:0] a, input logic [31:0] v, input logic [4:0] r);
    unit_valid[i] = 1'b1;
    unit_addr[i]  = a;
    unit_value[i] = v;
    unit_rs_id[i] = r;
  endtask

  task automatic rand_unit(input int i);
    logic [9:0] addr_tab[8];
    addr_tab = '{10'd1, 10'd8, 10'd9, 10'd1, 10'd8, 10'd9, 10'd5, 10'd1023};
    set_unit(i, addr_tab[$urandom_range(0, 7)], $urandom, 5'($urandom_range(0, 3)));
  endtask

  initial begin
    rst        = 1'b1;
    unit_valid = '0;
    unit_addr  = '0;
    unit_value = '0;
    unit_rs_id = '0;
    cdb_ready  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      own_v[s]  = 1'b0;
      own_rs[s] = '0;
    end
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single request into LR that still waits on rs 3
    own_v[1] = 1'b0; own_rs[1] = 5'd3;
    cdb_ready = 1'b1;
    set_unit(2, 10'd8, 32'hDEADBEEF, 5'd3);
    cycle();
    unit_valid = '0;
    cycle();
    cycle();

    // All units valid continuously from reset: 0,1,2,3,0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, 10'd1, 32'h100 + 32'(i), 5'(i));
    own_v[0] = 1'b0; own_rs[0] = 5'd2;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (m_last >= 0) unit_value[m_last] = unit_value[m_last] + 32'h10;
    end

    // Backpressure for 3 cycles with the stage full, then release
    cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    cdb_ready = 1'b1;
    cycle();
    unit_valid = '0;
    cycle();
    cycle();

    // Stale CTR result and a bad SPR number
    own_v[2] = 1'b0; own_rs[2] = 5'd7;
    set_unit(1, 10'd9, 32'h0000CAFE, 5'd4);
    cycle();
    unit_valid = '0;
    cycle();
    set_unit(3, 10'd5, 32'h12345678, 5'd1);
    cycle();
    unit_valid = '0;
    cycle();

    // Reset while the stage is full and stalled
    cdb_ready = 1'b0;
    set_unit(1, 10'd8, 32'h0BADF00D, 5'd3);
    cycle();
    unit_valid = '0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cdb_ready = 1'b1;
    cycle();
    set_unit(3, 10'd8, 32'h33, 5'd3);
    set_unit(0, 10'd9, 32'h44, 5'd1);
    cycle();
    unit_valid[0] = 1'b0;
    cycle();
    unit_valid = '0;
    cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (m_last >= 0) unit_valid[m_last] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!unit_valid[i] && $urandom_range(0, 99) < 55) rand_unit(i);
      for (int s = 0; s < 3; s++) begin
        own_v[s]  = 1'($urandom_range(0, 1));
        own_rs[s] = 5'($urandom_range(0, 3));
      end
      cdb_ready = ($urandom_range(0, 99) < 70);
      rst       = ($urandom_range(0, 99) < 2);
      cycle();
    end

    rst        = 1'b0;
    unit_valid = '0;
    cdb_ready  = 1'b1;
    cycle();
    cycle();
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
